// File: rtl/ocx_tlx_pkg.sv
// Shared opcodes, VC classification helpers and credit-return field positions
// for the TLX receive control scheduler.
package ocx_tlx_pkg;

  localparam logic [7:0] OPC_NOP          = 8'h00;
  localparam logic [7:0] OPC_RD_RESP      = 8'h01;
  localparam logic [7:0] OPC_RD_RESP_OW   = 8'h03;
  localparam logic [7:0] OPC_CRED_RET     = 8'h08;
  localparam logic [7:0] OPC_DMA_W        = 8'h81;
  localparam logic [7:0] OPC_DMA_W_BE     = 8'h82;
  localparam logic [7:0] OPC_DMA_PR_W     = 8'h86;
  localparam logic [7:0] OPC_ASSIGN_ACTAG = 8'hE0;
  localparam logic [7:0] OPC_INTRP_REQ_D  = 8'hE1;

  localparam int VCX_W           = 4;
  localparam int DCPX_W          = 6;
  localparam int VCX0_LO         = 8;
  localparam int DCPX0_LO        = 32;
  localparam int VCX3_LO_APOLLO  = 12;
  localparam int VCX3_LO_GEMINI  = 20;
  localparam int DCPX3_LO_APOLLO = 38;
  localparam int DCPX3_LO_GEMINI = 50;

  typedef enum logic [1:0] {VC_NONE = 2'd0, VC_0 = 2'd1, VC_1 = 2'd2} vc_e;

  function automatic vc_e vc_of(input logic [7:0] opc);
    if (opc >= 8'h20) return VC_1;
    if (opc == OPC_NOP || opc == OPC_CRED_RET) return VC_NONE;
    return VC_0;
  endfunction

  // Opcodes whose payload size comes from a dLength field
  function automatic logic has_dlen(input logic [7:0] opc);
    return (opc == OPC_RD_RESP) || (opc == OPC_RD_RESP_OW) || (opc == OPC_DMA_W);
  endfunction

  function automatic logic [2:0] flits_of(input logic [7:0] opc, input logic [1:0] dl);
    if (has_dlen(opc)) begin
      case (dl)
        2'b10:   return 3'd2;
        2'b11:   return 3'd4;
        default: return 3'd1;
      endcase
    end
    if (opc == OPC_DMA_W_BE || opc == OPC_DMA_PR_W || opc == OPC_INTRP_REQ_D) return 3'd1;
    return 3'd0;
  endfunction

endpackage

// File: rtl/ocx_tlx_ctl_vc_fifo.sv
// First-word-fall-through FIFO for one virtual channel; writes to a full FIFO
// are discarded, reads of an empty FIFO are ignored.
module ocx_tlx_ctl_vc_fifo #(
  parameter int WIDTH = 59,
  parameter int DEPTH = 8
) (
  input  logic             tlx_clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic             push, pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rp];

  always_ff @(posedge tlx_clk) begin
    if (push) mem[wp] <= wr_data;
  end

  always_ff @(posedge tlx_clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ocx_tlx_ctl_sched.sv
// TLX receive control scheduler: classifies parsed control slots into VC0/VC1
// FIFOs, gates head release on received data flits, and accumulates DL credits.
module ocx_tlx_ctl_sched
  import ocx_tlx_pkg::*;
#(
  parameter int CMD_W             = 168,
  parameter int FIFO_DEPTH        = 8,
  parameter int CRED_W            = 8,
  parameter int GEMINI_NOT_APOLLO = 0
) (
  input  logic              tlx_clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  pars_ctl_info,
  input  logic              pars_ctl_valid,
  input  logic [55:0]       credit_return,
  input  logic              credit_return_v,
  input  logic              data_flit_v,
  input  logic              data_flit_vc,
  output logic [55:0]       ctl_vc0_bus,
  output logic              ctl_vc0_v,
  input  logic              ctl_vc0_ready,
  output logic [CMD_W-1:0]  ctl_vc1_bus,
  output logic              ctl_vc1_v,
  input  logic              ctl_vc1_ready,
  output logic [2:0]        ctl_vc0_flits,
  output logic [2:0]        ctl_vc1_flits,
  output logic [CRED_W-1:0] rcv_xmt_credit_vcx0,
  output logic [CRED_W-1:0] rcv_xmt_credit_vcx3,
  output logic [CRED_W-1:0] rcv_xmt_credit_dcpx0,
  output logic [CRED_W-1:0] rcv_xmt_credit_dcpx3,
  output logic              rcv_xmt_credit_v,
  input  logic              rcv_xmt_credit_ack,
  output logic              fifo_ovf_err,
  output logic              dlen_err
);
  localparam int VC0_W    = 56;
  localparam int CNT_W    = $clog2(4*FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};
  localparam int VCX3_LO  = GEMINI_NOT_APOLLO ? VCX3_LO_GEMINI  : VCX3_LO_APOLLO;
  localparam int DCPX3_LO = GEMINI_NOT_APOLLO ? DCPX3_LO_GEMINI : DCPX3_LO_APOLLO;

  // Stage 1: register the parser slot
  logic [CMD_W-1:0] info_q;
  logic             vld_q;

  always_ff @(posedge tlx_clk) begin
    if (reset) begin
      info_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      info_q <= pars_ctl_info;
      vld_q  <= pars_ctl_valid;
    end
  end

  logic [7:0] opc;
  vc_e        vc;
  logic [1:0] dl;
  logic [2:0] flits;

  assign opc   = info_q[7:0];
  assign vc    = vc_of(opc);
  assign dl    = (opc == OPC_DMA_W) ? info_q[111:110] : info_q[27:26];
  assign flits = flits_of(opc, dl);

  // Stage 2: per-VC FIFOs carry {flits, bus}
  logic [1:0]       wr, full, empty, pop, hd_v, rdy, flit_inc;
  logic [1:0][2:0]  hd_flits;
  logic [VC0_W+2:0] vc0_dout;
  logic [CMD_W+2:0] vc1_dout;

  assign wr[0]    = vld_q & (vc == VC_0);
  assign wr[1]    = vld_q & (vc == VC_1);
  assign rdy      = {ctl_vc1_ready, ctl_vc0_ready};
  assign flit_inc = {data_flit_v & data_flit_vc, data_flit_v & ~data_flit_vc};

  ocx_tlx_ctl_vc_fifo #(.WIDTH(VC0_W+3), .DEPTH(FIFO_DEPTH)) u_vc0_fifo (
    .tlx_clk(tlx_clk), .reset(reset),
    .wr_en(wr[0]), .wr_data({flits, info_q[VC0_W-1:0]}),
    .rd_en(pop[0]), .rd_data(vc0_dout), .full(full[0]), .empty(empty[0])
  );

  ocx_tlx_ctl_vc_fifo #(.WIDTH(CMD_W+3), .DEPTH(FIFO_DEPTH)) u_vc1_fifo (
    .tlx_clk(tlx_clk), .reset(reset),
    .wr_en(wr[1]), .wr_data({flits, info_q}),
    .rd_en(pop[1]), .rd_data(vc1_dout), .full(full[1]), .empty(empty[1])
  );

  assign hd_flits[0] = vc0_dout[VC0_W +: 3];
  assign hd_flits[1] = vc1_dout[CMD_W +: 3];

  // Data flits may arrive before their command, so counts run ahead of the head
  logic [1:0][CNT_W-1:0] dcnt_q, dcnt_nxt;
  logic [1:0][CNT_W:0]   dsum;

  always_comb begin
    hd_v     = '0;
    pop      = '0;
    dsum     = '0;
    dcnt_nxt = dcnt_q;
    for (int i = 0; i < 2; i++) begin
      hd_v[i] = ~empty[i] & ((hd_flits[i] == 3'd0) | (dcnt_q[i] >= CNT_W'(hd_flits[i])));
      pop[i]  = hd_v[i] & rdy[i];
      dsum[i] = {1'b0, dcnt_q[i]} + (CNT_W+1)'(flit_inc[i])
                - (pop[i] ? (CNT_W+1)'(hd_flits[i]) : '0);
      dcnt_nxt[i] = (dsum[i] > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : dsum[i][CNT_W-1:0];
    end
  end

  always_ff @(posedge tlx_clk) begin
    if (reset) dcnt_q <= '0;
    else       dcnt_q <= dcnt_nxt;
  end

  assign ctl_vc0_v     = hd_v[0];
  assign ctl_vc1_v     = hd_v[1];
  assign ctl_vc0_bus   = empty[0] ? '0 : vc0_dout[VC0_W-1:0];
  assign ctl_vc1_bus   = empty[1] ? '0 : vc1_dout[CMD_W-1:0];
  assign ctl_vc0_flits = empty[0] ? '0 : hd_flits[0];
  assign ctl_vc1_flits = empty[1] ? '0 : hd_flits[1];

  // Sticky errors; a dropped entry does not also raise dlen_err
  always_ff @(posedge tlx_clk) begin
    if (reset) begin
      fifo_ovf_err <= 1'b0;
      dlen_err     <= 1'b0;
    end else begin
      if (|(wr & full)) fifo_ovf_err <= 1'b1;
      if (|(wr & ~full) && has_dlen(opc) && dl == 2'b00) dlen_err <= 1'b1;
    end
  end

  // Credit accumulators: 0=vcx0 1=vcx3 2=dcpx0 3=dcpx3
  logic [3:0][CRED_W-1:0] acc_q, acc_nxt, cr_in;
  logic [3:0][CRED_W:0]   acc_sum;
  logic                   cred_v;
  logic                   unused_cr;

  assign unused_cr = ^credit_return;
  assign cr_in[0]  = credit_return_v ? CRED_W'(credit_return[VCX0_LO  +: VCX_W])  : '0;
  assign cr_in[1]  = credit_return_v ? CRED_W'(credit_return[VCX3_LO  +: VCX_W])  : '0;
  assign cr_in[2]  = credit_return_v ? CRED_W'(credit_return[DCPX0_LO +: DCPX_W]) : '0;
  assign cr_in[3]  = credit_return_v ? CRED_W'(credit_return[DCPX3_LO +: DCPX_W]) : '0;
  assign cred_v    = |acc_q;

  // On ack the presented values leave; this cycle's return becomes the new base
  always_comb begin
    acc_sum = '0;
    acc_nxt = acc_q;
    for (int i = 0; i < 4; i++) begin
      acc_sum[i] = {1'b0, acc_q[i]} + {1'b0, cr_in[i]};
      if (rcv_xmt_credit_ack && cred_v) acc_nxt[i] = cr_in[i];
      else if (acc_sum[i][CRED_W])      acc_nxt[i] = {CRED_W{1'b1}};
      else                              acc_nxt[i] = acc_sum[i][CRED_W-1:0];
    end
  end

  always_ff @(posedge tlx_clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_nxt;
  end

  assign rcv_xmt_credit_vcx0  = acc_q[0];
  assign rcv_xmt_credit_vcx3  = acc_q[1];
  assign rcv_xmt_credit_dcpx0 = acc_q[2];
  assign rcv_xmt_credit_dcpx3 = acc_q[3];
  assign rcv_xmt_credit_v     = cred_v;

endmodule

// File: tb/tb_ocx_tlx_ctl_sched.sv
// Bench for ocx_tlx_ctl_sched: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_ocx_tlx_ctl_sched;
  localparam int CMD_W   = 168;
  localparam int D       = 8;
  localparam int CRED_W  = 8;
  localparam int CNT_MAX = 63;

  logic              tlx_clk = 1'b0;
  logic              reset = 1'b1;
  logic [CMD_W-1:0]  pars_ctl_info = '0;
  logic              pars_ctl_valid = 1'b0;
  logic [55:0]       credit_return = '0;
  logic              credit_return_v = 1'b0;
  logic              data_flit_v = 1'b0, data_flit_vc = 1'b0;
  logic              ctl_vc0_ready = 1'b0, ctl_vc1_ready = 1'b0, rcv_xmt_credit_ack = 1'b0;

  logic [55:0]       ctl_vc0_bus;
  logic [CMD_W-1:0]  ctl_vc1_bus;
  logic              ctl_vc0_v, ctl_vc1_v, rcv_xmt_credit_v, fifo_ovf_err, dlen_err;
  logic [2:0]        ctl_vc0_flits, ctl_vc1_flits;
  logic [CRED_W-1:0] vcx0, vcx3, dcpx0, dcpx3;

  logic [55:0]       b_vc0_bus;
  logic [CMD_W-1:0]  b_vc1_bus;
  logic              b_vc0_v, b_vc1_v, b_cred_v, b_ovf, b_dlen;
  logic [2:0]        b_vc0_flits, b_vc1_flits;
  logic [CRED_W-1:0] b_vcx0, b_vcx3, b_dcpx0, b_dcpx3;

  ocx_tlx_ctl_sched #(.CMD_W(CMD_W), .FIFO_DEPTH(D), .CRED_W(CRED_W), .GEMINI_NOT_APOLLO(0)) dut (
    .tlx_clk(tlx_clk), .reset(reset), .pars_ctl_info(pars_ctl_info), .pars_ctl_valid(pars_ctl_valid),
    .credit_return(credit_return), .credit_return_v(credit_return_v),
    .data_flit_v(data_flit_v), .data_flit_vc(data_flit_vc),
    .ctl_vc0_bus(ctl_vc0_bus), .ctl_vc0_v(ctl_vc0_v), .ctl_vc0_ready(ctl_vc0_ready),
    .ctl_vc1_bus(ctl_vc1_bus), .ctl_vc1_v(ctl_vc1_v), .ctl_vc1_ready(ctl_vc1_ready),
    .ctl_vc0_flits(ctl_vc0_flits), .ctl_vc1_flits(ctl_vc1_flits),
    .rcv_xmt_credit_vcx0(vcx0), .rcv_xmt_credit_vcx3(vcx3),
    .rcv_xmt_credit_dcpx0(dcpx0), .rcv_xmt_credit_dcpx3(dcpx3),
    .rcv_xmt_credit_v(rcv_xmt_credit_v), .rcv_xmt_credit_ack(rcv_xmt_credit_ack),
    .fifo_ovf_err(fifo_ovf_err), .dlen_err(dlen_err)
  );

  ocx_tlx_ctl_sched #(.CMD_W(CMD_W), .FIFO_DEPTH(D), .CRED_W(CRED_W), .GEMINI_NOT_APOLLO(1)) dut_g (
    .tlx_clk(tlx_clk), .reset(reset), .pars_ctl_info(pars_ctl_info), .pars_ctl_valid(pars_ctl_valid),
    .credit_return(credit_return), .credit_return_v(credit_return_v),
    .data_flit_v(data_flit_v), .data_flit_vc(data_flit_vc),
    .ctl_vc0_bus(b_vc0_bus), .ctl_vc0_v(b_vc0_v), .ctl_vc0_ready(ctl_vc0_ready),
    .ctl_vc1_bus(b_vc1_bus), .ctl_vc1_v(b_vc1_v), .ctl_vc1_ready(ctl_vc1_ready),
    .ctl_vc0_flits(b_vc0_flits), .ctl_vc1_flits(b_vc1_flits),
    .rcv_xmt_credit_vcx0(b_vcx0), .rcv_xmt_credit_vcx3(b_vcx3),
    .rcv_xmt_credit_dcpx0(b_dcpx0), .rcv_xmt_credit_dcpx3(b_dcpx3),
    .rcv_xmt_credit_v(b_cred_v), .rcv_xmt_credit_ack(rcv_xmt_credit_ack),
    .fifo_ovf_err(b_ovf), .dlen_err(b_dlen)
  );

  always #5 tlx_clk = ~tlx_clk;

  int vecs = 0, errs = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge tlx_clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [CMD_W-1:0] bus;
    int               flits;
  } ent_t;

  ent_t q0[$], q1[$];
  int   mcnt[2];
  int   macc[2][4];
  bit   movf, mdlen, s1_v;
  logic [CMD_W-1:0] s1_info;

  function automatic int dl_dec(input logic [1:0] d);
    if (d == 2'b10) return 2;
    if (d == 2'b11) return 4;
    return 1;
  endfunction

  function automatic int m_flits(input logic [CMD_W-1:0] info);
    logic [7:0] op;
    op = info[7:0];
    if (op == 8'h01 || op == 8'h03) return dl_dec(info[27:26]);
    if (op == 8'h81) return dl_dec(info[111:110]);
    if (op == 8'h82 || op == 8'h86 || op == 8'hE1) return 1;
    return 0;
  endfunction

  function automatic bit m_dlen_bad(input logic [CMD_W-1:0] info);
    logic [7:0] op;
    op = info[7:0];
    if (op == 8'h01 || op == 8'h03) return info[27:26] == 2'b00;
    if (op == 8'h81) return info[111:110] == 2'b00;
    return 1'b0;
  endfunction

  function automatic bit m_v(input int vc);
    if (vc == 0) return q0.size() > 0 && (q0[0].flits == 0 || mcnt[0] >= q0[0].flits);
    return q1.size() > 0 && (q1[0].flits == 0 || mcnt[1] >= q1[0].flits);
  endfunction

  task automatic model_step();
    bit   pop0, pop1, full0, full1, cv;
    int   n, rel, inc;
    int   in[2][4];
    logic [7:0] op;
    ent_t e;
    if (reset) begin
      q0.delete(); q1.delete();
      mcnt = '{0, 0};
      for (int m = 0; m < 2; m++) for (int i = 0; i < 4; i++) macc[m][i] = 0;
      movf = 0; mdlen = 0; s1_v = 0; s1_info = '0;
      return;
    end
    pop0  = m_v(0) && ctl_vc0_ready;
    pop1  = m_v(1) && ctl_vc1_ready;
    full0 = q0.size() == D;
    full1 = q1.size() == D;
    for (int v = 0; v < 2; v++) begin
      inc = (data_flit_v && data_flit_vc == v) ? 1 : 0;
      rel = 0;
      if (v == 0 && pop0) rel = q0[0].flits;
      if (v == 1 && pop1) rel = q1[0].flits;
      n = mcnt[v] + inc - rel;
      mcnt[v] = (n > CNT_MAX) ? CNT_MAX : n;
    end
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (s1_v) begin
      op = s1_info[7:0];
      e.flits = m_flits(s1_info);
      if (op >= 8'h20) begin
        e.bus = s1_info;
        if (full1) movf = 1;
        else begin q1.push_back(e); if (m_dlen_bad(s1_info)) mdlen = 1; end
      end else if (op != 8'h00 && op != 8'h08) begin
        e.bus = '0;
        e.bus[55:0] = s1_info[55:0];
        if (full0) movf = 1;
        else begin q0.push_back(e); if (m_dlen_bad(s1_info)) mdlen = 1; end
      end
    end
    for (int m = 0; m < 2; m++) begin
      in[m][0] = credit_return_v ? int'(credit_return[11:8]) : 0;
      in[m][2] = credit_return_v ? int'(credit_return[37:32]) : 0;
      in[m][1] = !credit_return_v ? 0 : (m == 0) ? int'(credit_return[15:12]) : int'(credit_return[23:20]);
      in[m][3] = !credit_return_v ? 0 : (m == 0) ? int'(credit_return[43:38]) : int'(credit_return[55:50]);
      cv = (macc[m][0] | macc[m][1] | macc[m][2] | macc[m][3]) != 0;
      for (int i = 0; i < 4; i++) begin
        if (rcv_xmt_credit_ack && cv) macc[m][i] = in[m][i];
        else macc[m][i] = (macc[m][i] + in[m][i] > 255) ? 255 : macc[m][i] + in[m][i];
      end
    end
    s1_v    = pars_ctl_valid;
    s1_info = pars_ctl_info;
  endtask

  always @(posedge tlx_clk) model_step();

  always @(negedge tlx_clk) begin
    if (cmp_en) begin
      chk("vc0_v", ctl_vc0_v, m_v(0));
      chk("vc1_v", ctl_vc1_v, m_v(1));
      chk("vc0_bus", ctl_vc0_bus, q0.size() ? q0[0].bus[55:0] : 56'd0);
      chk("vc1_bus", ctl_vc1_bus, q1.size() ? q1[0].bus : '0);
      chk("vc0_flits", ctl_vc0_flits, q0.size() ? q0[0].flits : 0);
      chk("vc1_flits", ctl_vc1_flits, q1.size() ? q1[0].flits : 0);
      chk("vcx0", vcx0, macc[0][0]);
      chk("vcx3", vcx3, macc[0][1]);
      chk("dcpx0", dcpx0, macc[0][2]);
      chk("dcpx3", dcpx3, macc[0][3]);
      chk("cred_v", rcv_xmt_credit_v, (macc[0][0] | macc[0][1] | macc[0][2] | macc[0][3]) != 0);
      chk("g_vcx3", b_vcx3, macc[1][1]);
      chk("g_dcpx3", b_dcpx3, macc[1][3]);
      chk("ovf", fifo_ovf_err, movf);
      chk("dlen", dlen_err, mdlen);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [CMD_W-1:0] rnd_info(input logic [7:0] op);
    logic [191:0] t;
    for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom;
    t[7:0] = op;
    return t[CMD_W-1:0];
  endfunction

  logic [7:0] ops [14] = '{8'h00, 8'h08, 8'h01, 8'h03, 8'h04, 8'h1F, 8'h20,
                           8'h81, 8'h82, 8'h86, 8'hE0, 8'hE1, 8'hFF, 8'h3C};

  initial begin
    logic [CMD_W-1:0] info;
    logic [63:0]      r64;
    logic [7:0]       op;

    cyc();
    cmp_en = 1'b1;
    cyc();
    chk("rst_vc0_v", ctl_vc0_v, 1'b0);
    chk("rst_vc1_v", ctl_vc1_v, 1'b0);
    chk("rst_cred_v", rcv_xmt_credit_v, 1'b0);
    chk("rst_errs", {fifo_ovf_err, dlen_err}, 2'b00);
    chk("rst_vc1_bus", ctl_vc1_bus, '0);
    reset = 1'b0;

    // VC0 no-data command, released two cycles later
    info = rnd_info(8'h04);
    pars_ctl_info = info; pars_ctl_valid = 1'b1; ctl_vc0_ready = 1'b1;
    cyc(); pars_ctl_valid = 1'b0;
    cyc();
    chk("t1_v", ctl_vc0_v, 1'b1);
    chk("t1_bus", ctl_vc0_bus, info[55:0]);
    chk("t1_flits", ctl_vc0_flits, 3'd0);
    cyc();
    chk("t1_popped", ctl_vc0_v, 1'b0);

    // VC1 0x81 dL=11 waits for four flits
    info = rnd_info(8'h81); info[111:110] = 2'b11;
    pars_ctl_info = info; pars_ctl_valid = 1'b1; ctl_vc1_ready = 1'b1;
    cyc(); pars_ctl_valid = 1'b0;
    cyc();
    chk("t2_wait0", ctl_vc1_v, 1'b0);
    data_flit_v = 1'b1; data_flit_vc = 1'b1;
    repeat (3) cyc();
    chk("t2_wait3", ctl_vc1_v, 1'b0);
    cyc(); data_flit_v = 1'b0;
    chk("t2_v", ctl_vc1_v, 1'b1);
    chk("t2_flits", ctl_vc1_flits, 3'd4);
    chk("t2_bus", ctl_vc1_bus, info);
    cyc();
    chk("t2_popped", ctl_vc1_v, 1'b0);

    // Flits before command; NOP and credit-return opcodes never enqueue
    data_flit_v = 1'b1; data_flit_vc = 1'b0;
    cyc(); cyc(); data_flit_v = 1'b0;
    info = rnd_info(8'h01); info[27:26] = 2'b10;
    pars_ctl_info = info; pars_ctl_valid = 1'b1;
    cyc(); pars_ctl_valid = 1'b0;
    cyc();
    chk("t3_v", ctl_vc0_v, 1'b1);
    chk("t3_flits", ctl_vc0_flits, 3'd2);
    pars_ctl_info = rnd_info(8'h00); pars_ctl_valid = 1'b1;
    cyc(); pars_ctl_info = rnd_info(8'h08);
    cyc(); pars_ctl_valid = 1'b0;
    cyc(); cyc();
    chk("t3_nop", {ctl_vc0_v, ctl_vc1_v}, 2'b00);

    // dL=00 on a data-bearing opcode counts as one flit and flags dlen_err
    info = rnd_info(8'h81); info[111:110] = 2'b00;
    pars_ctl_info = info; pars_ctl_valid = 1'b1; data_flit_v = 1'b1; data_flit_vc = 1'b1;
    cyc(); pars_ctl_valid = 1'b0; data_flit_v = 1'b0;
    cyc();
    chk("t4_dlen", dlen_err, 1'b1);
    chk("t4_flits", ctl_vc1_flits, 3'd1);
    chk("t4_v", ctl_vc1_v, 1'b1);
    cyc();

    // Overflow: D+1 writes with ready low, then drain in order
    ctl_vc1_ready = 1'b0;
    for (int k = 0; k <= D; k++) begin
      info = rnd_info(8'hE0); info[15:8] = 8'(k);
      pars_ctl_info = info; pars_ctl_valid = 1'b1;
      cyc();
    end
    pars_ctl_valid = 1'b0;
    cyc(); cyc();
    chk("t5_ovf", fifo_ovf_err, 1'b1);
    ctl_vc1_ready = 1'b1;
    for (int k = 0; k < D; k++) begin
      chk("t5_drain_v", ctl_vc1_v, 1'b1);
      chk("t5_drain_tag", ctl_vc1_bus[15:8], k);
      cyc();
    end
    chk("t5_empty", ctl_vc1_v, 1'b0);
    chk("t5_sticky", fifo_ovf_err, 1'b1);

    // Credits
    credit_return = '0; credit_return[11:8] = 4'd3; credit_return_v = 1'b1;
    cyc(); credit_return[11:8] = 4'd5;
    cyc(); credit_return_v = 1'b0;
    chk("t6_acc8", vcx0, 8'd8);
    chk("t6_cv", rcv_xmt_credit_v, 1'b1);
    rcv_xmt_credit_ack = 1'b1; credit_return[11:8] = 4'd2; credit_return_v = 1'b1;
    cyc(); rcv_xmt_credit_ack = 1'b0; credit_return_v = 1'b0;
    chk("t6_ack_ret", vcx0, 8'd2);
    credit_return = '0;
    credit_return[15:12] = 4'd1; credit_return[23:20] = 4'd2;
    credit_return[43:38] = 6'd3; credit_return[55:50] = 6'd4;
    credit_return_v = 1'b1;
    cyc(); credit_return_v = 1'b0;
    chk("t6_apollo_vcx3", vcx3, 8'd1);
    chk("t6_apollo_dcpx3", dcpx3, 8'd3);
    chk("t6_gemini_vcx3", b_vcx3, 8'd2);
    chk("t6_gemini_dcpx3", b_dcpx3, 8'd4);
    rcv_xmt_credit_ack = 1'b1;
    cyc(); rcv_xmt_credit_ack = 1'b0;
    chk("t6_clear", rcv_xmt_credit_v, 1'b0);
    credit_return = '0; credit_return[11:8] = 4'd4; credit_return_v = 1'b1; rcv_xmt_credit_ack = 1'b1;
    cyc(); credit_return_v = 1'b0; rcv_xmt_credit_ack = 1'b0;
    chk("t6_ack_idle", vcx0, 8'd4);
    rcv_xmt_credit_ack = 1'b1;
    cyc(); rcv_xmt_credit_ack = 1'b0;
    credit_return[11:8] = 4'd15; credit_return_v = 1'b1;
    repeat (17) cyc();
    chk("t6_ff", vcx0, 8'hFF);
    credit_return[11:8] = 4'd1;
    cyc(); credit_return_v = 1'b0;
    chk("t6_sat", vcx0, 8'hFF);

    // Reset with entries pending
    ctl_vc0_ready = 1'b0; ctl_vc1_ready = 1'b0;
    pars_ctl_info = rnd_info(8'h04); pars_ctl_valid = 1'b1;
    cyc(); pars_ctl_info = rnd_info(8'hE0);
    cyc(); pars_ctl_valid = 1'b0;
    cyc();
    chk("t7_pending", {ctl_vc0_v, ctl_vc1_v}, 2'b11);
    reset = 1'b1;
    cyc(); reset = 1'b0;
    chk("t7_v", {ctl_vc0_v, ctl_vc1_v}, 2'b00);
    chk("t7_err", {fifo_ovf_err, dlen_err}, 2'b00);
    chk("t7_cred", rcv_xmt_credit_v, 1'b0);
    cyc();
    chk("t7_empty", {ctl_vc0_v, ctl_vc1_v}, 2'b00);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      op = ops[$urandom_range(0, 13)];
      if ($urandom_range(0, 7) == 0) op = 8'($urandom);
      pars_ctl_info  = rnd_info(op);
      pars_ctl_valid = $urandom_range(0, 1);
      data_flit_v    = ($urandom_range(0, 9) < 3);
      data_flit_vc   = $urandom_range(0, 1);
      ctl_vc0_ready  = ($urandom_range(0, 9) < 6);
      ctl_vc1_ready  = ((n / 200) % 3 == 2) ? 1'b0 : ($urandom_range(0, 9) < 6);
      r64 = {$urandom, $urandom};
      credit_return      = r64[55:0];
      credit_return_v    = ($urandom_range(0, 9) < 3);
      rcv_xmt_credit_ack = ($urandom_range(0, 9) < 2);
      reset = ($urandom_range(0, 499) == 0);
      cyc();
    end
    reset = 1'b0; pars_ctl_valid = 1'b0; data_flit_v = 1'b0; credit_return_v = 1'b0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
